link_rx: RTL and testbench
==========================

// Module: link_rx
// PURPOSE
//  Serial-link receive side: UART deserializer on UART_RX feeding the CPU serial registers.
//  Bytes are buffered in a small FIFO.
//  When the CPU arms a transfer (SC bit7 at 0xFF02), the oldest byte moves into SB (0xFF01) and the serial IRQ pulses.
//  Shares the CPU bus with the link transmitter; the top level ORs outdata of both.
// PARAMETERS
//  CLKS_PER_BIT  36  clock4 cycles per UART bit (4.194304 MHz / 115200 ~ 36.4)
//  FIFO_AW       2   log2 FIFO depth (default 4 entries)
// PORTS
//  clock4    in   1   system clock; the only clock
//  reset     in   1   asynchronous, active-high reset
//  address   in   16  CPU address
//  indata    in   8   CPU write data
//  outdata   out  8   CPU read data, registered
//  load      in   1   CPU read strobe, 1 cycle
//  store     in   1   CPU write strobe, 1 cycle
//  UART_RX   in   1   async serial input, idle high
//  irq       out  1   serial interrupt request, 1-cycle pulse
// BEHAVIOUR
//  Reset: outdata=0, irq=0, SB=0xFF, armed=0, ferr=0, ovf=0, FIFO empty, FSM IDLE, synchronizer flops=1.
//  UART_RX passes through a 2-flop synchronizer (rx_s) before any use.
//  Deserializer FSM, counter cnt, bit index bi (0..7):
//   IDLE : rx_s==0 -> START, cnt=CLKS_PER_BIT/2-1.
//   START: cnt==0 -> if rx_s==0: DATA, cnt=CLKS_PER_BIT-1, bi=0; else glitch -> IDLE.
//   DATA : cnt==0 -> shift rx_s into bit bi (LSB first), cnt reload; bi==7 -> STOP.
//   STOP : cnt==0 -> if rx_s==1, push byte; else set ferr and drop byte. Go to IDLE.
//  New start bit is accepted from the first IDLE cycle after STOP (mid-stop-bit).
//  FIFO: push when full -> byte dropped, ovf=1, contents untouched.
//  Pop condition: armed && !empty, evaluated from registered state.
//   On pop: SB <= head, armed <= 0, irq=1 for exactly that one cycle.
//  Push and pop in the same cycle: both happen.
//   Full stays full; no overflow.
//   Empty: the pushed byte is not bypassed; it pops on the next cycle.
//  Latency, stop-bit sample to SB/irq when armed: 2 clocks (push cycle, then pop cycle).
//  Store 0xFF01: SB <= indata. A pop in the same cycle wins.
//  Store 0xFF02:
//   armed <= indata[7];
//   indata[1]=1 clears ovf; indata[0]=1 clears ferr.
//   If a flag is set by hardware in the same cycle as its clear, it stays set.
//  Load (outdata updates the cycle after load; holds otherwise):
//   0xFF01 -> SB
//   0xFF02 -> {armed, 4'b0, !empty, ovf, ferr}
//   any other address -> 8'h00
//  Writing armed=1 while already armed is harmless.
//  Writing armed=0 cancels the pending transfer; the FIFO is untouched.
//  Asserting reset mid-frame aborts it: FSM returns to IDLE, FIFO is flushed.
//  Bus address compares are full 16-bit; load and store in the same cycle -> store wins.
//  cnt width: $clog2(CLKS_PER_BIT). FIFO pointers are FIFO_AW+1 bits, with wrap-around by natural overflow.
// STRUCTURE
//  Shared package link_pkg:
//   address constants ADDR_SB=16'hFF01, ADDR_SC=16'hFF02
//   SC bit positions SC_START=7, SC_OVF=1, SC_FERR=0
//   rx FSM state enum {IDLE, START, DATA, STOP}
//  Sub-module link_rx_fifo (params FIFO_AW, width 8):
//   ports push, din, pop, dout, empty, full.
//   link_rx keeps the synchronizer, FSM and register/bus logic.
// TESTING
//  1. Reset, then store FF02=0x80; drive 0x5A 8N1 at 36 clk/bit.
//     -> irq pulses once; load FF01 = 0x5A; load FF02 = 0x00.
//  2. Unarmed; receive 0x11,0x22,0x33,0x44,0x55.
//     -> FF02 reads 0x06 (nonempty, ovf).
//     -> Then arm 4 times: SB = 0x11,0x22,0x33,0x44, one irq each.
//     -> Afterwards FF02 reads 0x02; write FF02=0x02 -> 0x00.
//  3. Frame 0xA5 with stop bit driven 0.
//     -> ferr=1, FIFO stays empty, no irq.
//     -> Next good frame 0x3C is received correctly.
//  4. 8-cycle low glitch on UART_RX in IDLE -> FSM back to IDLE, no push, no flags.
//  5. FIFO full and armed, 5th byte's stop sample in the same cycle as the pop.
//     -> no ovf; FIFO stays full; SB = oldest byte.
//  6. Assert reset mid-DATA of a frame.
//     -> all reset values restored; the following full frame 0xC3 is received intact.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the serial link: CPU register addresses, SC bit positions
// and the receive deserializer state encoding.
package link_pkg;

   localparam logic [15:0] ADDR_SB = 16'hFF01;
   localparam logic [15:0] ADDR_SC = 16'hFF02;

   localparam int SC_START = 7;
   localparam int SC_OVF   = 1;
   localparam int SC_FERR  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/link_rx_fifo.sv
// Small byte FIFO between the UART deserializer and SB. Pointers carry one extra
// wrap bit; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module link_rx_fifo #(
   parameter int FIFO_AW = 2
) (
   input  logic       clock4,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge clock4 or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clock4) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= din;
   end

endmodule

// File: rtl/link_rx.sv
// Serial-link receiver: synchronized UART 8N1 deserializer feeding a byte FIFO,
// drained one byte per armed transfer into SB with a one-cycle serial interrupt.
module link_rx
   import link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 36,
   parameter int FIFO_AW      = 2
) (
   input  logic        clock4,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  indata,
   output logic [7:0]  outdata,
   input  logic        load,
   input  logic        store,
   input  logic        UART_RX,
   output logic        irq
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic            sync1;
   logic            rx_s;
   rx_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bi_q, bi_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            frame_ok;
   logic            frame_bad;

   logic [7:0]      sb;
   logic            armed;
   logic            ovf;
   logic            ferr;

   logic [7:0]      fifo_dout;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            sb_wr;
   logic            sc_wr;
   logic            rd;
   logic            ovf_set;

   always_ff @(posedge clock4 or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= UART_RX;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clock4 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bi_q    <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bi_q    <= bi_d;
         shreg_q <= shreg_d;
      end
   end

   // Start bit is re-checked at its middle; data and stop bits are sampled one bit-time apart.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bi_d      = bi_q;
      shreg_d   = shreg_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = CNT_HALF;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d = DATA;
                  cnt_d   = CNT_FULL;
                  bi_d    = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shreg_d[bi_q] = rx_s;
               cnt_d         = CNT_FULL;
               bi_d          = bi_q + 3'd1;
               if (bi_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               frame_ok  = rx_s;
               frame_bad = !rx_s;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   link_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clock4 (clock4),
      .reset  (reset),
      .push   (frame_ok),
      .din    (shreg_q),
      .pop    (pop),
      .dout   (fifo_dout),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   assign pop     = armed && !fifo_empty;
   assign sb_wr   = store && (address == ADDR_SB);
   assign sc_wr   = store && (address == ADDR_SC);
   assign rd      = load && !store;
   // A simultaneous pop frees the slot, so a full FIFO only overflows without one.
   assign ovf_set = frame_ok && fifo_full && !pop;

   always_ff @(posedge clock4 or posedge reset) begin
      if (reset) begin
         outdata <= 8'h00;
         irq     <= 1'b0;
         sb      <= 8'hFF;
         armed   <= 1'b0;
         ovf     <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         irq <= pop;
         if (pop)        sb <= fifo_dout;
         else if (sb_wr) sb <= indata;
         if (sc_wr)      armed <= indata[SC_START];
         else if (pop)   armed <= 1'b0;
         ovf  <= ovf_set   || (ovf  && !(sc_wr && indata[SC_OVF]));
         ferr <= frame_bad || (ferr && !(sc_wr && indata[SC_FERR]));
         if (rd) begin
            if (address == ADDR_SB)      outdata <= sb;
            else if (address == ADDR_SC) outdata <= {armed, 4'b0000, !fifo_empty, ovf, ferr};
            else                         outdata <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_link_rx.sv
// Directed bench for link_rx: UART frames driven bit by bit, CPU register reads
// compared against hand-computed values.
module tb_link_rx;

   localparam logic [15:0] SB = 16'hFF01;
   localparam logic [15:0] SC = 16'hFF02;

   logic        clock4 = 1'b0;
   logic        reset  = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [7:0]  indata  = 8'h00;
   logic [7:0]  outdata;
   logic        load    = 1'b0;
   logic        store   = 1'b0;
   logic        UART_RX = 1'b1;
   logic        irq;

   int checks  = 0;
   int errors  = 0;
   int irq_cnt = 0;
   int exp_irq = 0;

   link_rx #(.CLKS_PER_BIT(36), .FIFO_AW(2)) dut (
      .clock4  (clock4),
      .reset   (reset),
      .address (address),
      .indata  (indata),
      .outdata (outdata),
      .load    (load),
      .store   (store),
      .UART_RX (UART_RX),
      .irq     (irq)
   );

   always #5 clock4 = ~clock4;

   always @(negedge clock4) begin
      if (irq === 1'b1) irq_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock4);
   endtask

   task automatic send_bit(input logic b, input int n);
      @(negedge clock4);
      UART_RX = b;
      repeat (n - 1) @(negedge clock4);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_val, input int stop_len);
      send_bit(1'b0, 36);
      for (int i = 0; i < 8; i++) send_bit(d[i], 36);
      send_bit(stop_val, stop_len);
      send_bit(1'b1, 8);
   endtask

   task automatic cpu_store(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock4);
      address = a;
      indata  = d;
      store   = 1'b1;
      @(negedge clock4);
      store   = 1'b0;
   endtask

   task automatic cpu_load(input logic [15:0] a, output logic [7:0] v);
      @(negedge clock4);
      address = a;
      load    = 1'b1;
      @(negedge clock4);
      load    = 1'b0;
      v       = outdata;
   endtask

   logic [7:0] v;
   logic [7:0] fill5 [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
   logic [7:0] t2    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      // Reset values
      idle(3);
      #1;
      check("reset_outdata", outdata, 8'h00);
      check("reset_irq", irq, 1'b0);
      reset = 1'b0;
      idle(4);
      cpu_load(SB, v);  check("reset_sb", v, 8'hFF);
      cpu_load(SC, v);  check("reset_sc", v, 8'h00);

      // 1: armed single transfer
      cpu_store(SC, 8'h80);
      send_byte(8'h5A, 1'b1, 36);
      idle(4);
      exp_irq = 1;
      check("t1_irq", irq_cnt, exp_irq);
      cpu_load(SB, v);  check("t1_sb", v, 8'h5A);
      cpu_load(SC, v);  check("t1_sc", v, 8'h00);
      cpu_load(SB, v);
      cpu_load(16'h0001, v); check("t1_addr_0001", v, 8'h00);
      cpu_load(SB, v);
      cpu_load(16'hFF03, v); check("t1_addr_ff03", v, 8'h00);

      // 2: overflow, then four armed transfers
      send_byte(8'h11, 1'b1, 36);
      send_byte(8'h22, 1'b1, 36);
      send_byte(8'h33, 1'b1, 36);
      send_byte(8'h44, 1'b1, 36);
      send_byte(8'h55, 1'b1, 36);
      cpu_load(SC, v);  check("t2_sc_ovf", v, 8'h06);
      check("t2_no_irq", irq_cnt, exp_irq);
      for (int i = 0; i < 4; i++) begin
         cpu_store(SC, 8'h80);
         idle(4);
         exp_irq++;
         cpu_load(SB, v);  check("t2_sb", v, t2[i]);
         check("t2_irq", irq_cnt, exp_irq);
      end
      cpu_load(SC, v);  check("t2_sc_after", v, 8'h02);
      cpu_store(SC, 8'h02);
      cpu_load(SC, v);  check("t2_sc_clr", v, 8'h00);

      // 3: framing error, then a good frame
      cpu_store(SC, 8'h80);
      send_byte(8'hA5, 1'b0, 28);
      idle(40);
      cpu_load(SC, v);  check("t3_sc_ferr", v, 8'h81);
      check("t3_no_irq", irq_cnt, exp_irq);
      send_byte(8'h3C, 1'b1, 36);
      idle(4);
      exp_irq++;
      check("t3_irq", irq_cnt, exp_irq);
      cpu_load(SB, v);  check("t3_sb", v, 8'h3C);
      cpu_load(SC, v);  check("t3_sc", v, 8'h01);
      cpu_store(SC, 8'h01);
      cpu_load(SC, v);  check("t3_sc_clr", v, 8'h00);

      // 4: short low glitch while idle
      @(negedge clock4);
      UART_RX = 1'b0;
      idle(8);
      UART_RX = 1'b1;
      idle(400);
      cpu_load(SC, v);  check("t4_sc", v, 8'h00);
      check("t4_no_irq", irq_cnt, exp_irq);

      // 5: full FIFO, arm lands so the pop coincides with the 5th stop sample
      send_byte(8'h01, 1'b1, 36);
      send_byte(8'h02, 1'b1, 36);
      send_byte(8'h03, 1'b1, 36);
      send_byte(8'h04, 1'b1, 36);
      cpu_load(SC, v);  check("t5_sc_full", v, 8'h04);
      fork
         send_byte(8'h05, 1'b1, 36);
         begin
            idle(343);
            cpu_store(SC, 8'h80);
         end
      join
      idle(4);
      exp_irq++;
      check("t5_irq", irq_cnt, exp_irq);
      cpu_load(SC, v);  check("t5_sc_no_ovf", v, 8'h04);
      cpu_load(SB, v);  check("t5_sb_oldest", v, 8'h01);
      for (int i = 0; i < 4; i++) begin
         cpu_store(SC, 8'h80);
         idle(4);
         exp_irq++;
         cpu_load(SB, v);  check("t5_drain_sb", v, fill5[i]);
      end
      check("t5_drain_irq", irq_cnt, exp_irq);
      cpu_load(SC, v);  check("t5_sc_empty", v, 8'h00);

      // 6: reset in the middle of a frame
      send_byte(8'h99, 1'b1, 36);
      cpu_store(SB, 8'h12);
      cpu_load(SB, v);  check("t6_sb_store", v, 8'h12);
      cpu_load(SC, v);  check("t6_sc_pre", v, 8'h04);
      send_bit(1'b0, 36);
      send_bit(1'b1, 36);
      send_bit(1'b0, 36);
      send_bit(1'b1, 20);
      @(negedge clock4);
      reset   = 1'b1;
      UART_RX = 1'b1;
      #1;
      check("t6_rst_outdata", outdata, 8'h00);
      check("t6_rst_irq", irq, 1'b0);
      idle(2);
      reset = 1'b0;
      idle(400);
      cpu_load(SB, v);  check("t6_sb", v, 8'hFF);
      cpu_load(SC, v);  check("t6_sc", v, 8'h00);
      send_byte(8'hC3, 1'b1, 36);
      cpu_load(SC, v);  check("t6_sc_rx", v, 8'h04);
      cpu_store(SC, 8'h80);
      idle(4);
      exp_irq++;
      cpu_load(SB, v);  check("t6_sb_c3", v, 8'hC3);
      check("t6_irq", irq_cnt, exp_irq);
      cpu_load(SC, v);  check("t6_sc_end", v, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
